// File: rtl/sram_word_ctrl.sv
// Word-to-byte controller for an asynchronous 32K x 8 SRAM (big-endian, four byte cycles per word).
// Optional per-byte write mask enabled with `define SRAM_CTRL_BYTEMASK_EN (adds REQ_BE).
`timescale 1ns/1ps
module sram_word_ctrl #(
    parameter int ADDR_W      = 15,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [ADDR_W-3:0] REQ_ADDR,
    input  logic [31:0]       REQ_WDATA,
`ifdef SRAM_CTRL_BYTEMASK_EN
    input  logic [3:0]        REQ_BE,
`endif
    output logic              RSP_VALID,
    output logic [31:0]       RSP_RDATA,
    output logic [ADDR_W-1:0] A,
    inout  wire  [7:0]        IO,
    output logic              CS,
    output logic              OE,
    output logic              WE
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_RECOVER = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [1:0]        idx_r, idx_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [31:0]       rbuf_r, rbuf_s;
    logic              accept_s;

    logic              we_r;
    logic [ADDR_W-3:0] addr_r;
    logic [31:0]       wdata_r;
    logic [3:0]        be_r;
    logic [3:0]        req_be_s;

    logic              cur_we_s, wr_drive_s;
    logic [ADDR_W-3:0] cur_addr_s;
    logic [31:0]       cur_wdata_s;
    logic [3:0]        cur_be_s;

    logic              ready_r, ready_s, rsp_valid_r, rsp_valid_s;
    logic [31:0]       rdata_r, rdata_s;
    logic [ADDR_W-1:0] a_r, a_s;
    logic              cs_r, cs_s, oe_r, oe_s, we_out_r, we_out_s;
    logic              io_oe_r, io_oe_s;
    logic [7:0]        io_out_r, io_out_s;

`ifdef SRAM_CTRL_BYTEMASK_EN
    assign req_be_s = REQ_BE;
`else
    assign req_be_s = 4'b1111;
`endif

    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    word_byte = word[31:24];
            2'd1:    word_byte = word[23:16];
            2'd2:    word_byte = word[15:8];
            default: word_byte = word[7:0];
        endcase
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                             input logic [7:0] b);
        put_byte = word;
        case (idx)
            2'd0:    put_byte[31:24] = b;
            2'd1:    put_byte[23:16] = b;
            2'd2:    put_byte[15:8]  = b;
            default: put_byte[7:0]   = b;
        endcase
    endfunction

    // Next-state, byte index, strobe counter and read byte capture
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        cnt_s    = cnt_r;
        rbuf_s   = rbuf_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (REQ_VALID && ready_r) begin
                    accept_s = 1'b1;
                    state_s  = ST_SETUP;
                    idx_s    = 2'd0;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s = ST_STROBE;
                cnt_s   = {CNT_W{1'b0}};
            end
            ST_STROBE: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_RECOVER;
                    if (!we_r) begin
                        rbuf_s = put_byte(rbuf_r, idx_r, IO);
                    end else begin
                        rbuf_s = rbuf_r;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_RECOVER: begin
                if (idx_r == 2'd3) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SETUP;
                    idx_s   = idx_r + 2'd1;
                end
            end
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Output values for the state being entered; request fields come straight from the
    // requester on the acceptance edge because the latch updates on that same edge.
    always_comb begin
        cur_we_s    = accept_s ? REQ_WE    : we_r;
        cur_addr_s  = accept_s ? REQ_ADDR  : addr_r;
        cur_wdata_s = accept_s ? REQ_WDATA : wdata_r;
        cur_be_s    = accept_s ? req_be_s  : be_r;
        wr_drive_s  = cur_we_s && cur_be_s[2'd3 - idx_s];
        cs_s        = 1'b1;
        oe_s        = 1'b1;
        we_out_s    = 1'b1;
        io_oe_s     = 1'b0;
        io_out_s    = io_out_r;
        a_s         = a_r;
        case (state_s)
            ST_SETUP: begin
                cs_s     = 1'b0;
                oe_s     = cur_we_s;
                a_s      = {cur_addr_s, idx_s};
                io_oe_s  = wr_drive_s;
                io_out_s = word_byte(cur_wdata_s, idx_s);
            end
            ST_STROBE: begin
                cs_s     = 1'b0;
                oe_s     = cur_we_s;
                we_out_s = ~wr_drive_s;
                io_oe_s  = wr_drive_s;
            end
            ST_RECOVER: io_oe_s = wr_drive_s;
            default:    cs_s    = 1'b1;
        endcase
        ready_s     = (state_s == ST_IDLE);
        rsp_valid_s = (state_s == ST_DONE);
        if ((state_s == ST_DONE) && !we_r) begin
            rdata_s = rbuf_r;
        end else begin
            rdata_s = rdata_r;
        end
    end

    // FSM state, byte index, strobe counter and read assembly buffer
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
            idx_r   <= 2'd0;
            cnt_r   <= {CNT_W{1'b0}};
            rbuf_r  <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
            rbuf_r  <= rbuf_s;
        end
    end

    // Request latch, loaded only on acceptance
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            we_r    <= 1'b0;
            addr_r  <= {(ADDR_W-2){1'b0}};
            wdata_r <= 32'h0000_0000;
            be_r    <= 4'b0000;
        end else if (accept_s) begin
            we_r    <= REQ_WE;
            addr_r  <= REQ_ADDR;
            wdata_r <= REQ_WDATA;
            be_r    <= req_be_s;
        end else begin
            we_r    <= we_r;
        end
    end

    // Registered SRAM strobes, address, data drive and requester handshake
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ready_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            rdata_r     <= 32'h0000_0000;
            a_r         <= {ADDR_W{1'b0}};
            cs_r        <= 1'b1;
            oe_r        <= 1'b1;
            we_out_r    <= 1'b1;
            io_oe_r     <= 1'b0;
            io_out_r    <= 8'h00;
        end else begin
            ready_r     <= ready_s;
            rsp_valid_r <= rsp_valid_s;
            rdata_r     <= rdata_s;
            a_r         <= a_s;
            cs_r        <= cs_s;
            oe_r        <= oe_s;
            we_out_r    <= we_out_s;
            io_oe_r     <= io_oe_s;
            io_out_r    <= io_out_s;
        end
    end

    assign REQ_READY = ready_r;
    assign RSP_VALID = rsp_valid_r;
    assign RSP_RDATA = rdata_r;
    assign A         = a_r;
    assign CS        = cs_r;
    assign OE        = oe_r;
    assign WE        = we_out_r;
    assign IO        = io_oe_r ? io_out_r : 8'hzz;

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Directed self-checking bench for sram_word_ctrl with a behavioural 32K x 8 SRAM.
`timescale 1ns/1ps
module tb_sram_word_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic        REQ_WE = 1'b0;
    logic [12:0] REQ_ADDR = 13'h0000;
    logic [31:0] REQ_WDATA = 32'h0000_0000;
    logic [3:0]  req_be = 4'hF;
    logic        RSP_VALID;
    logic [31:0] RSP_RDATA;
    logic [14:0] A;
    wire  [7:0]  IO;
    logic        CS, OE, WE;

    logic [7:0]  mem [0:32767];
    int          checks = 0;
    int          errors = 0;
    int          mon_err = 0;
    int          mon_samples = 0;
    logic        strobe_prev = 1'b0;
    logic [14:0] a_prev = 15'h0000;

    sram_word_ctrl dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
`ifdef SRAM_CTRL_BYTEMASK_EN
        .REQ_BE(req_be),
`endif
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
        .A(A), .IO(IO), .CS(CS), .OE(OE), .WE(WE)
    );

    always #5 CLK = ~CLK;

    // SRAM model: released bus floats high, reads drive while CS/OE low, writes latch on WE rise
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup pu (IO[g]);
    end
    assign IO = (CS === 1'b0 && OE === 1'b0 && WE === 1'b1) ? mem[A] : 8'hzz;
    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
        mem[0] = 8'h5A;
        forever begin
            @(posedge WE);
            if (RST === 1'b0) mem[A] = IO;
        end
    end

    // Bus rule monitor: no OE/WE overlap, A stable under a strobe, no contention on reads
    always @(negedge CLK) begin
        if (RST === 1'b0) begin
            mon_samples <= mon_samples + 1;
            mon_err <= mon_err + int'(WE === 1'b0 && OE === 1'b0)
                     + int'((WE === 1'b0 || OE === 1'b0) && strobe_prev && A !== a_prev)
                     + int'(CS === 1'b0 && OE === 1'b0 && IO !== mem[A]);
            strobe_prev <= (WE === 1'b0) || (OE === 1'b0);
            a_prev <= A;
        end else begin
            strobe_prev <= 1'b0;
        end
    end

    task automatic do_req(input logic we, input logic [12:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output int lat, output logic ready_low,
                          output logic [31:0] rdata);
        int n;
        lat = -1; ready_low = 1'b1; rdata = 32'h0; n = 0;
        while (REQ_READY !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        REQ_VALID = 1'b1; REQ_WE = we; REQ_ADDR = addr; REQ_WDATA = wdata; req_be = be;
        @(posedge CLK);
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge CLK);
            REQ_VALID = 1'b0; REQ_WE = ~we; REQ_ADDR = ~addr; REQ_WDATA = ~wdata; req_be = ~be;
            if (REQ_READY !== 1'b0) ready_low = 1'b0;
            if (RSP_VALID === 1'b1) begin
                lat = k - 1;
                rdata = RSP_RDATA;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        checks++; if ({CS, OE, WE} !== 3'b111) begin errors++; $display("FAIL rst_strobes got %b exp 111", {CS, OE, WE}); end
        checks++; if (IO !== 8'hFF) begin errors++; $display("FAIL rst_io got %h exp released", IO); end
        checks++; if (A !== 15'h0000) begin errors++; $display("FAIL rst_addr got %h exp 0000", A); end
        checks++; if (REQ_READY !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", REQ_READY); end
        checks++; if (RSP_VALID !== 1'b0 || RSP_RDATA !== 32'h0) begin errors++; $display("FAIL rst_rsp got %b/%h exp 0/0", RSP_VALID, RSP_RDATA); end
        RST = 1'b0;
        @(negedge CLK);
        checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b exp 1", REQ_READY); end
    endtask

    task automatic test_write();
        int lat; logic rl; logic [31:0] rd;
        do_req(1'b1, 13'h0010, 32'hDEADBEEF, 4'hF, lat, rl, rd);
        checks++; if (lat !== 16) begin errors++; $display("FAIL wr_latency got %0d exp 16", lat); end
        checks++; if (rl !== 1'b1) begin errors++; $display("FAIL wr_ready_low got %b exp 1", rl); end
        checks++; if ({mem[15'h40], mem[15'h41], mem[15'h42], mem[15'h43]} !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_bytes got %h%h%h%h exp deadbeef", mem[15'h40], mem[15'h41], mem[15'h42], mem[15'h43]);
        end
    endtask

    task automatic test_read();
        int lat; logic rl; logic [31:0] rd;
        do_req(1'b0, 13'h0010, 32'h0, 4'hF, lat, rl, rd);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h exp deadbeef", rd); end
        checks++; if (lat !== 16) begin errors++; $display("FAIL rd_latency got %0d exp 16", lat); end
        @(negedge CLK);
        checks++; if (RSP_VALID !== 1'b0 || RSP_RDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold got %b/%h exp 0/deadbeef", RSP_VALID, RSP_RDATA); end
    endtask

    task automatic test_top_word();
        int lat; logic rl; logic [31:0] rd;
        do_req(1'b1, 13'h1FFF, 32'h01234567, 4'hF, lat, rl, rd);
        checks++; if ({mem[15'h7FFC], mem[15'h7FFD], mem[15'h7FFE], mem[15'h7FFF]} !== 32'h01234567) begin
            errors++; $display("FAIL top_bytes got %h%h%h%h exp 01234567", mem[15'h7FFC], mem[15'h7FFD], mem[15'h7FFE], mem[15'h7FFF]);
        end
        checks++; if (mem[0] !== 8'h5A) begin errors++; $display("FAIL top_no_wrap got %h exp 5a", mem[0]); end
        checks++; if (RSP_RDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_keeps_rdata got %h exp deadbeef", RSP_RDATA); end
        do_req(1'b0, 13'h1FFF, 32'h0, 4'hF, lat, rl, rd);
        checks++; if (rd !== 32'h01234567) begin errors++; $display("FAIL top_read got %h exp 01234567", rd); end
    endtask

    task automatic test_back_to_back();
        int rsp1, rsp2, rdy_first, rdy_cnt, rsp_cnt, n;
        logic [31:0] rd;
        rsp1 = -1; rsp2 = -1; rdy_first = -1; rdy_cnt = 0; rsp_cnt = 0; rd = 32'h0; n = 0;
        while (REQ_READY !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
        REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 13'h0030; REQ_WDATA = 32'h0BADF00D; req_be = 4'hF;
        @(posedge CLK);
        for (int k = 1; k <= 36; k++) begin
            @(negedge CLK);
            if (k == 1) begin REQ_WE = 1'b0; REQ_WDATA = 32'h0; end
            if (k == 35) REQ_VALID = 1'b0;
            if (REQ_READY === 1'b1) begin
                rdy_cnt++;
                if (rdy_first < 0) rdy_first = k;
            end
            if (RSP_VALID === 1'b1) begin
                rsp_cnt++;
                if (rsp1 < 0) rsp1 = k;
                else if (rsp2 < 0) begin rsp2 = k; rd = RSP_RDATA; end
            end
        end
        REQ_VALID = 1'b0;
        checks++; if (rsp1 !== 17) begin errors++; $display("FAIL b2b_rsp1 got %0d exp 17", rsp1); end
        checks++; if (rdy_first !== 18 || rdy_cnt !== 2) begin errors++; $display("FAIL b2b_ready got first %0d count %0d exp 18/2", rdy_first, rdy_cnt); end
        checks++; if (rsp2 !== 35 || rsp_cnt !== 2) begin errors++; $display("FAIL b2b_rsp2 got %0d count %0d exp 35/2", rsp2, rsp_cnt); end
        checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL b2b_read got %h exp 0badf00d", rd); end
    endtask

    task automatic test_abort();
        int n, lat; logic seen, rl; logic [31:0] rd;
        n = 0; seen = 1'b0;
        while (REQ_READY !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
        REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 13'h0020; REQ_WDATA = 32'hCAFEF00D; req_be = 4'hF;
        @(posedge CLK);
        for (int k = 1; k <= 10; k++) begin @(negedge CLK); REQ_VALID = 1'b0; end
        checks++; if (WE !== 1'b0 || A !== 15'h0082 || IO !== 8'hF0) begin errors++; $display("FAIL abort_strobe got WE=%b A=%h IO=%h exp 0/0082/f0", WE, A, IO); end
        #2 RST = 1'b1;
        #1;
        checks++; if ({CS, OE, WE} !== 3'b111 || IO !== 8'hFF || A !== 15'h0000) begin
            errors++; $display("FAIL abort_immediate got %b IO=%h A=%h exp 111/ff/0000", {CS, OE, WE}, IO, A);
        end
        checks++; if (RSP_VALID !== 1'b0 || RSP_RDATA !== 32'h0 || REQ_READY !== 1'b0) begin
            errors++; $display("FAIL abort_rsp got %b/%h/%b exp 0/0/0", RSP_VALID, RSP_RDATA, REQ_READY);
        end
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 0; k < 24; k++) begin
            @(negedge CLK);
            if (RSP_VALID !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0 || REQ_READY !== 1'b1) begin errors++; $display("FAIL abort_no_rsp got rsp %b ready %b exp 0/1", seen, REQ_READY); end
        do_req(1'b0, 13'h0010, 32'h0, 4'hF, lat, rl, rd);
        checks++; if (rd !== 32'hDEADBEEF || lat !== 16) begin errors++; $display("FAIL abort_readback got %h lat %0d exp deadbeef/16", rd, lat); end
    endtask

`ifdef SRAM_CTRL_BYTEMASK_EN
    task automatic test_bytemask();
        int lat; logic rl; logic [31:0] rd;
        do_req(1'b1, 13'h0050, 32'h11223344, 4'b1111, lat, rl, rd);
        do_req(1'b1, 13'h0050, 32'hAABBCCDD, 4'b1010, lat, rl, rd);
        checks++; if (lat !== 16) begin errors++; $display("FAIL be_latency got %0d exp 16", lat); end
        do_req(1'b0, 13'h0050, 32'h0, 4'b0000, lat, rl, rd);
        checks++; if (rd !== 32'hAA22CC44) begin errors++; $display("FAIL be_read got %h exp aa22cc44", rd); end
    endtask
`endif

    task automatic test_strobe_rules();
        checks++; if (mon_err !== 0 || mon_samples < 100) begin
            errors++; $display("FAIL strobe_rules got %0d violations in %0d samples exp 0", mon_err, mon_samples);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_top_word();
        test_back_to_back();
        test_abort();
`ifdef SRAM_CTRL_BYTEMASK_EN
        test_bytemask();
`endif
        test_strobe_rules();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
